// File: rtl/regread_port.sv
// Registered dual-operand read port for the 32x32 register array with valid/ready handshakes.
// Optional write-to-read forwarding from G/R_in is enabled by defining REGREAD_BYPASS_EN.
module regread_port #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [31:0]      r0,
    input  logic [31:0]      r1,
    input  logic [31:0]      r2,
    input  logic [31:0]      r3,
    input  logic [31:0]      r4,
    input  logic [31:0]      r5,
    input  logic [31:0]      r6,
    input  logic [31:0]      r7,
    input  logic [31:0]      r8,
    input  logic [31:0]      r9,
    input  logic [31:0]      r10,
    input  logic [31:0]      r11,
    input  logic [31:0]      r12,
    input  logic [31:0]      r13,
    input  logic [31:0]      r14,
    input  logic [31:0]      r15,
    input  logic [31:0]      r16,
    input  logic [31:0]      r17,
    input  logic [31:0]      r18,
    input  logic [31:0]      r19,
    input  logic [31:0]      r20,
    input  logic [31:0]      r21,
    input  logic [31:0]      r22,
    input  logic [31:0]      r23,
    input  logic [31:0]      r24,
    input  logic [31:0]      r25,
    input  logic [31:0]      r26,
    input  logic [31:0]      r27,
    input  logic [31:0]      r28,
    input  logic [31:0]      r29,
    input  logic [31:0]      r30,
    input  logic [31:0]      r31,
    input  logic [31:0]      G,
    input  logic [31:0]      R_in,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      a_out,
    output logic [31:0]      b_out,
    output logic [CNT_W-1:0] rd_count
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        arr_s [32];
    logic [31:0]        a_sel_s, b_sel_s;
    logic               accept_s;
    logic               unused_s;

`ifdef REGREAD_BYPASS_EN
    // Forward the value being written this edge; slot 0 is never forwarded.
    function automatic logic [31:0] pick(input logic [4:0]  idx,
                                         input logic [31:0] arr_val,
                                         input logic [31:0] wdata,
                                         input logic [31:0] wen);
        if ((idx != 5'd0) && wen[idx]) begin
            return wdata;
        end else begin
            return arr_val;
        end
    endfunction
`endif

    // r0 is never read: index 0 is hardwired to zero. Sink keeps bypass-only inputs tidy.
    assign unused_s = ^{r0, G, R_in};

    // Array view of the parallel register outputs with slot 0 forced to zero.
    always_comb begin
        arr_s[0]  = 32'h0000_0000; arr_s[1]  = r1;  arr_s[2]  = r2;  arr_s[3]  = r3;
        arr_s[4]  = r4;  arr_s[5]  = r5;  arr_s[6]  = r6;  arr_s[7]  = r7;
        arr_s[8]  = r8;  arr_s[9]  = r9;  arr_s[10] = r10; arr_s[11] = r11;
        arr_s[12] = r12; arr_s[13] = r13; arr_s[14] = r14; arr_s[15] = r15;
        arr_s[16] = r16; arr_s[17] = r17; arr_s[18] = r18; arr_s[19] = r19;
        arr_s[20] = r20; arr_s[21] = r21; arr_s[22] = r22; arr_s[23] = r23;
        arr_s[24] = r24; arr_s[25] = r25; arr_s[26] = r26; arr_s[27] = r27;
        arr_s[28] = r28; arr_s[29] = r29; arr_s[30] = r30; arr_s[31] = r31;
    end

    // Operand selection for both read indices.
    always_comb begin
`ifdef REGREAD_BYPASS_EN
        a_sel_s = pick(rs1, arr_s[rs1], G, R_in);
        b_sel_s = pick(rs2, arr_s[rs2], G, R_in);
`else
        a_sel_s = arr_s[rs1];
        b_sel_s = arr_s[rs2];
`endif
    end

    assign accept_s = req_valid && req_ready;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (accept_s) begin
                    state_d = ST_FULL;
                end else if (rsp_ready) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        rsp_valid = 1'b0;
        case (state_q)
            ST_EMPTY: rsp_valid = 1'b0;
            ST_FULL:  rsp_valid = 1'b1;
            default:  rsp_valid = 1'b0;
        endcase
        req_ready = !rsp_valid || rsp_ready;
    end

    // Operand snapshots and accept counter load only on an accepted request.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        if (accept_s) begin
            a_d   = a_sel_s;
            b_d   = b_sel_s;
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            a_d   = a_q;
            b_d   = b_q;
            cnt_d = cnt_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_q   <= 32'h0000_0000;
            b_q   <= 32'h0000_0000;
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
        end
    end

    assign a_out    = a_q;
    assign b_out    = b_q;
    assign rd_count = cnt_q;

endmodule

// File: tb/tb_regread_port.sv
// Randomized self-checking bench for regread_port against a transaction-level reference model.
module tb_regread_port;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             resetn = 1'b1;
    logic [31:0]      regs [32];
    logic [31:0]      G = 32'h0;
    logic [31:0]      R_in = 32'h0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [4:0]       rs1 = 5'd0;
    logic [4:0]       rs2 = 5'd0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [31:0]      a_out, b_out;
    logic [CNT_W-1:0] rd_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic             m_valid = 1'b0;
    logic [31:0]      m_a = 32'h0, m_b = 32'h0;
    logic [CNT_W-1:0] m_cnt = '0;

    always #5 clk = ~clk;

    regread_port #(.CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn),
        .r0(regs[0]),   .r1(regs[1]),   .r2(regs[2]),   .r3(regs[3]),
        .r4(regs[4]),   .r5(regs[5]),   .r6(regs[6]),   .r7(regs[7]),
        .r8(regs[8]),   .r9(regs[9]),   .r10(regs[10]), .r11(regs[11]),
        .r12(regs[12]), .r13(regs[13]), .r14(regs[14]), .r15(regs[15]),
        .r16(regs[16]), .r17(regs[17]), .r18(regs[18]), .r19(regs[19]),
        .r20(regs[20]), .r21(regs[21]), .r22(regs[22]), .r23(regs[23]),
        .r24(regs[24]), .r25(regs[25]), .r26(regs[26]), .r27(regs[27]),
        .r28(regs[28]), .r29(regs[29]), .r30(regs[30]), .r31(regs[31]),
        .G(G), .R_in(R_in),
        .req_valid(req_valid), .req_ready(req_ready),
        .rs1(rs1), .rs2(rs2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .a_out(a_out), .b_out(b_out), .rd_count(rd_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Value the read port should return for index i given the current array/write bus.
    function automatic logic [31:0] model_val(input int i);
        if (i == 0) return 32'h0;
`ifdef REGREAD_BYPASS_EN
        if (R_in[i]) return G;
`endif
        return regs[i];
    endfunction

    // One clock: check ready, predict the edge, then compare outputs after it.
    task automatic step();
        logic             acc;
        logic             n_valid;
        logic [31:0]      n_a, n_b;
        logic [CNT_W-1:0] n_cnt;
        #1;
        check_eq("req_ready", req_ready, !m_valid || rsp_ready);
        acc     = req_valid && (!m_valid || rsp_ready);
        n_valid = m_valid; n_a = m_a; n_b = m_b; n_cnt = m_cnt;
        if (acc) begin
            n_valid = 1'b1;
            n_a     = model_val(int'(rs1));
            n_b     = model_val(int'(rs2));
            n_cnt   = m_cnt + 1'b1;
        end else if (rsp_ready) begin
            n_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        m_valid = n_valid; m_a = n_a; m_b = n_b; m_cnt = n_cnt;
        check_eq("rsp_valid", rsp_valid, m_valid);
        check_eq("a_out", a_out, m_a);
        check_eq("b_out", b_out, m_b);
        check_eq("rd_count", rd_count, m_cnt);
    endtask

    // Asynchronous reset between edges; returns at a negedge with resetn released.
    task automatic do_reset();
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_a_out", a_out, 32'h0);
        check_eq("rst_b_out", b_out, 32'h0);
        check_eq("rst_rd_count", rd_count, 0);
        check_eq("rst_req_ready", req_ready, 1'b1);
        m_valid = 1'b0; m_a = 32'h0; m_b = 32'h0; m_cnt = '0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        do_reset();

        // Single read on the first edge after reset release
        regs[5] = 32'hDEADBEEF; regs[9] = 32'h12345678;
        rs1 = 5'd5; rs2 = 5'd9; req_valid = 1'b1; rsp_ready = 1'b0;
        step();
        check_eq("single_a", a_out, 32'hDEADBEEF);
        check_eq("single_b", b_out, 32'h12345678);
        check_eq("single_cnt", rd_count, 1);
        req_valid = 1'b0; rsp_ready = 1'b1;
        step();

        // Index 0 reads as zero regardless of r0
        regs[0] = 32'hFFFFFFFF; rs1 = 5'd0; rs2 = 5'd0; req_valid = 1'b1;
        step();
        check_eq("zero_a", a_out, 32'h0);
        check_eq("zero_b", b_out, 32'h0);

        // Back-pressure: held snapshot while the array and request change
        rs1 = 5'd5; rs2 = 5'd9; req_valid = 1'b1; rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0; rs1 = 5'd3; rs2 = 5'd4;
        for (int k = 0; k < 4; k++) begin
            regs[5] = $urandom;
            step();
            check_eq("bp_hold_a", a_out, 32'hDEADBEEF);
            check_eq("bp_hold_cnt", rd_count, 3);
        end
        rsp_ready = 1'b1;
        step();
        check_eq("bp_release_a", a_out, regs[3]);
        check_eq("bp_release_cnt", rd_count, 4);

        // Streaming from a fresh reset
        do_reset();
        rsp_ready = 1'b1; req_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            rs1 = 5'(k); rs2 = 5'(31 - k);
            step();
            check_eq("stream_valid", rsp_valid, 1'b1);
        end
        check_eq("stream_cnt", rd_count, 10);
        req_valid = 1'b0;
        step();

        // Write-to-read forwarding
        regs[7] = 32'h1; G = 32'hA5A5A5A5; R_in = 32'h80;
        rs1 = 5'd7; rs2 = 5'd7; req_valid = 1'b1;
        step();
`ifdef REGREAD_BYPASS_EN
        check_eq("bypass_a", a_out, 32'hA5A5A5A5);
`else
        check_eq("bypass_a", a_out, 32'h1);
`endif
        R_in = 32'h0;

        // Async reset while FULL and stalled
        rs1 = 5'd9; req_valid = 1'b1; rsp_ready = 1'b0;
        step();
        do_reset();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            regs[$urandom_range(0, 31)] = $urandom;
            req_valid = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            rs1 = 5'($urandom_range(0, 31));
            rs2 = ($urandom_range(0, 7) == 0) ? rs1 : 5'($urandom_range(0, 31));
            G = $urandom;
            R_in = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
